// File: rtl/t2t_pkg.sv
// ---------------------------------------------------------------------------
// t2t_pkg
// Shared types and constants for the tick-to-trade feed path.
//   T2T_MSG_BEATS : number of 64-bit beats in a well-formed market message
//   t_avalon_msg  : one Avalon-ST beat (valid/sop/eop/data)
//   t_arb_state   : feed arbiter FSM states
//   len_bad()     : true when a message length differs from T2T_MSG_BEATS
// ---------------------------------------------------------------------------
package t2t_pkg;

   localparam int T2T_MSG_BEATS = 3;
   localparam int T2T_DATA_W    = 64;

   typedef struct packed {
      logic                  valid;
      logic                  sop;
      logic                  eop;
      logic [T2T_DATA_W-1:0] data;
   } t_avalon_msg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } t_arb_state;

   // A message ending after 'beats' beats is malformed unless it has exactly
   // the nominal beat count.
   function automatic logic len_bad(input int unsigned beats);
      return (beats != T2T_MSG_BEATS);
   endfunction

endpackage

// File: rtl/t2t_rr_pick.sv
// ---------------------------------------------------------------------------
// t2t_rr_pick
// Combinational round-robin picker. Searches req starting at last_grant+1
// and wrapping, returning the first requester found.
// Ports:
//   req        in  N   request vector
//   last_grant in  W   index granted most recently (lowest priority now)
//   grant      out W   index of the chosen requester (0 when none)
//   any        out 1   at least one request is set
// ---------------------------------------------------------------------------
module t2t_rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_grant,
   output logic [W-1:0] grant,
   output logic         any
);

   logic [W-1:0] idx_s;

   // Priority scan from the slot after the previous winner, wrapping round.
   always_comb begin
      grant = {W{1'b0}};
      any   = 1'b0;
      idx_s = {W{1'b0}};
      for (int k = 1; k <= N; k++) begin
         idx_s = W'((int'(last_grant) + k) % N);
         if (!any && req[idx_s]) begin
            any   = 1'b1;
            grant = idx_s;
         end else begin
            any   = any;
         end
      end
   end

endmodule

// File: rtl/t2t_feed_arb.sv
// ---------------------------------------------------------------------------
// t2t_feed_arb
// Message-atomic round-robin arbiter merging N_FEEDS Avalon-ST feeds into a
// single decoder stream. A grant is held from sop to eop so messages never
// interleave. Orphan beats (no sop, not from the granted feed) are dropped
// and counted; messages running past MAX_BEATS are truncated with a forced
// eop. Output is a single registered stage with decoder backpressure.
// Ports:
//   clk        in  1               rising-edge clock
//   reset      in  1               asynchronous, active-high
//   in_msg     in  N_FEEDS beats   per-feed valid/sop/eop/data
//   in_ready   out N_FEEDS         per-feed accept (transfer on valid&&ready)
//   out_msg    out 1 beat          merged stream to decoder (registered)
//   out_ready  in  1               decoder accept
//   out_src    out clog2(N_FEEDS)  feed index of the beat on out_msg
//   len_err    out 1               one-cycle pulse on length/framing violation
//   drop_cnt   out CNT_W           saturating count of dropped orphan beats
//   err_cnt    out CNT_W           saturating count of len_err pulses
// ---------------------------------------------------------------------------
module t2t_feed_arb
   import t2t_pkg::*;
#(
   parameter int N_FEEDS   = 4,
   parameter int MAX_BEATS = 3,
   parameter int CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  t_avalon_msg                in_msg [N_FEEDS],
   output logic [N_FEEDS-1:0]         in_ready,
   output t_avalon_msg                out_msg,
   input  logic                       out_ready,
   output logic [$clog2(N_FEEDS)-1:0] out_src,
   output logic                       len_err,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic [CNT_W-1:0]           err_cnt
);

   localparam int SRC_W = $clog2(N_FEEDS);
   localparam int BC_W  = $clog2(MAX_BEATS + 1);

   // Saturating add of a per-cycle drop count onto a counter.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   t_arb_state       state_r;
   t_arb_state       state_nxt_s;
   logic [SRC_W-1:0] last_grant_r;
   logic [BC_W-1:0]  beat_cnt_r;
   logic [BC_W-1:0]  beat_cnt_nxt_s;
   logic [BC_W-1:0]  beat_inc_s;

   t_avalon_msg      out_msg_r;
   logic [SRC_W-1:0] out_src_r;
   logic             len_err_r;
   logic [CNT_W-1:0] drop_cnt_r;
   logic [CNT_W-1:0] err_cnt_r;

   logic             out_free_s;
   logic [N_FEEDS-1:0] req_s;
   logic [N_FEEDS-1:0] orphan_s;
   logic [3:0]       orphan_n_s;
   logic [SRC_W-1:0] pick_s;
   logic             pick_any_s;
   t_avalon_msg      cur_s;
   t_avalon_msg      pick_msg_s;

   logic [N_FEEDS-1:0] ready_s;
   logic             accept_s;
   logic             grant_s;
   logic [SRC_W-1:0] acc_src_s;
   logic             acc_sop_s;
   logic             acc_eop_s;
   logic [T2T_DATA_W-1:0] acc_data_s;
   logic             len_err_s;

   // The output register can take a new beat when empty or being drained.
   assign out_free_s = !out_msg_r.valid || out_ready;
   assign beat_inc_s = beat_cnt_r + BC_W'(1);
   assign cur_s      = in_msg[last_grant_r];
   assign pick_msg_s = in_msg[pick_s];

   // Start-of-message requests and orphan detection per feed. While idle no
   // feed owns the grant, so every non-sop beat is an orphan.
   always_comb begin
      req_s    = {N_FEEDS{1'b0}};
      orphan_s = {N_FEEDS{1'b0}};
      for (int i = 0; i < N_FEEDS; i++) begin
         req_s[i]    = in_msg[i].valid && in_msg[i].sop;
         orphan_s[i] = in_msg[i].valid && !in_msg[i].sop &&
                       ((state_r == ARB_IDLE) || (SRC_W'(i) != last_grant_r));
      end
   end

   // Number of orphan beats discarded this cycle.
   always_comb begin
      orphan_n_s = 4'd0;
      for (int i = 0; i < N_FEEDS; i++) begin
         orphan_n_s = orphan_n_s + {3'd0, orphan_s[i]};
      end
   end

   t2t_rr_pick #(
      .N (N_FEEDS),
      .W (SRC_W)
   ) u_pick (
      .req        (req_s),
      .last_grant (last_grant_r),
      .grant      (pick_s),
      .any        (pick_any_s)
   );

   // Arbiter FSM: next state, feed accepts and the beat to load downstream.
   always_comb begin
      state_nxt_s    = state_r;
      beat_cnt_nxt_s = beat_cnt_r;
      ready_s        = orphan_s;
      accept_s       = 1'b0;
      grant_s        = 1'b0;
      acc_src_s      = last_grant_r;
      acc_sop_s      = 1'b0;
      acc_eop_s      = 1'b0;
      acc_data_s     = {T2T_DATA_W{1'b0}};
      len_err_s      = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            if (pick_any_s && out_free_s) begin
               ready_s[pick_s] = 1'b1;
               accept_s        = 1'b1;
               grant_s         = 1'b1;
               acc_src_s       = pick_s;
               acc_sop_s       = 1'b1;
               acc_eop_s       = pick_msg_s.eop;
               acc_data_s      = pick_msg_s.data;
               beat_cnt_nxt_s  = BC_W'(1);
               if (pick_msg_s.eop) begin
                  len_err_s   = len_bad(32'd1);
                  state_nxt_s = ARB_IDLE;
               end else begin
                  state_nxt_s = ARB_LOCKED;
               end
            end else begin
               state_nxt_s = ARB_IDLE;
            end
         end
         ARB_LOCKED: begin
            ready_s[last_grant_r] = out_free_s;
            if (cur_s.valid && out_free_s) begin
               accept_s   = 1'b1;
               acc_sop_s  = cur_s.sop;
               acc_data_s = cur_s.data;
               if (cur_s.sop) begin
                  // A new sop restarts the message in place of the open one.
                  len_err_s      = 1'b1;
                  beat_cnt_nxt_s = BC_W'(1);
                  acc_eop_s      = cur_s.eop;
                  if (cur_s.eop) begin
                     state_nxt_s = ARB_IDLE;
                  end else begin
                     state_nxt_s = ARB_LOCKED;
                  end
               end else if (cur_s.eop) begin
                  beat_cnt_nxt_s = beat_inc_s;
                  acc_eop_s      = 1'b1;
                  len_err_s      = len_bad(32'(beat_inc_s));
                  state_nxt_s    = ARB_IDLE;
               end else if (beat_inc_s == BC_W'(MAX_BEATS)) begin
                  // Over-length: close the message with a forced eop.
                  beat_cnt_nxt_s = beat_inc_s;
                  acc_eop_s      = 1'b1;
                  len_err_s      = 1'b1;
                  state_nxt_s    = ARB_IDLE;
               end else begin
                  beat_cnt_nxt_s = beat_inc_s;
                  state_nxt_s    = ARB_LOCKED;
               end
            end else begin
               state_nxt_s = ARB_LOCKED;
            end
         end
         default: begin
            state_nxt_s    = ARB_IDLE;
            beat_cnt_nxt_s = {BC_W{1'b0}};
            ready_s        = {N_FEEDS{1'b0}};
         end
      endcase
   end

   // No feed is accepted while reset is held.
   assign in_ready = reset ? {N_FEEDS{1'b0}} : ready_s;

   // FSM state, grant pointer and beat counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ARB_IDLE;
         last_grant_r <= SRC_W'(N_FEEDS - 1);
         beat_cnt_r   <= {BC_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         beat_cnt_r <= beat_cnt_nxt_s;
         if (grant_s) begin
            last_grant_r <= pick_s;
         end
      end
   end

   // Output stage: load on accept, clear valid once the decoder takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_msg_r <= '{valid: 1'b0, sop: 1'b0, eop: 1'b0,
                        data: {T2T_DATA_W{1'b0}}};
         out_src_r <= {SRC_W{1'b0}};
      end else if (accept_s) begin
         out_msg_r <= '{valid: 1'b1, sop: acc_sop_s, eop: acc_eop_s,
                        data: acc_data_s};
         out_src_r <= acc_src_s;
      end else if (out_ready) begin
         out_msg_r.valid <= 1'b0;
         out_msg_r.sop   <= 1'b0;
         out_msg_r.eop   <= 1'b0;
      end
   end

   // Error pulse and saturating drop/error counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_err_r  <= 1'b0;
         drop_cnt_r <= {CNT_W{1'b0}};
         err_cnt_r  <= {CNT_W{1'b0}};
      end else begin
         len_err_r  <= len_err_s;
         drop_cnt_r <= sat_add(drop_cnt_r, orphan_n_s);
         if (len_err_s) begin
            err_cnt_r <= sat_add(err_cnt_r, 4'd1);
         end
      end
   end

   assign out_msg  = out_msg_r;
   assign out_src  = out_src_r;
   assign len_err  = len_err_r;
   assign drop_cnt = drop_cnt_r;
   assign err_cnt  = err_cnt_r;

endmodule
